// File: rtl/layer_write_scheduler.sv
// Per-row layer write scheduler: issues the layer-1 background pass, then up to three clipped
// sprite spans, through a ROM_LAT-deep write delay line. SCHED_OVERRUN_CNT_EN adds overrun_count.
module layer_write_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ROM_LAT  = 1
) (
   input  logic        Clk50,
   input  logic        Reset,
   input  logic        row_start,
   input  logic [9:0]  row_y,
   input  logic [2:0]  span_req,
   input  logic [29:0] span_x0,
   input  logic [29:0] span_w,
   output logic [9:0]  issue_X,
   output logic [9:0]  issue_Y,
   output logic [2:0]  issue_layer,
   output logic [9:0]  write_X,
   output logic [9:0]  write_Y,
   output logic [2:0]  write_which_layer,
   output logic        buffer_select,
   output logic        busy,
   output logic [2:0]  span_ack,
   output logic        overrun
`ifdef SCHED_OVERRUN_CNT_EN
   ,output logic [7:0]  overrun_count
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_L1, S_ARB, S_SPAN, S_DRAIN} state_e;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] layer;
   } wr_ent_t;

   localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [10:0] H_W      = 11'(H_ACTIVE);
   localparam logic [10:0] V_W      = 11'(V_ACTIVE);
   localparam logic [1:0]  DRN_LAST = 2'(ROM_LAT - 1);

   state_e           state_q, state_d;
   logic [9:0]       x_q, x_d;
   logic [10:0]      end_q, end_d;
   logic [1:0]       sel_q, sel_d;
   logic [9:0]       y_q, y_d;
   logic [2:0]       pend_q, pend_d;
   logic [2:0][9:0]  x0_q, x0_d;
   logic [2:0][9:0]  w_q, w_d;
   logic             bsel_q, bsel_d;
   logic [1:0]       drn_q, drn_d;
   wr_ent_t [ROM_LAT-1:0] pipe_q;

   logic        accept;
   logic [1:0]  arb_sel;
   logic [9:0]  arb_x0, arb_w;
   logic [10:0] arb_sum, arb_end;
   logic        arb_skip;

   assign accept        = row_start && ({1'b0, row_y} < V_W);
   assign busy          = (state_q != S_IDLE);
   assign overrun       = accept && busy;
   assign issue_Y       = busy ? y_q : 10'd0;
   assign buffer_select = bsel_q;

   // Lowest pending layer wins; the 11-bit sum cannot wrap before clipping.
   always_comb begin
      arb_sel  = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
      arb_x0   = x0_q[arb_sel];
      arb_w    = w_q[arb_sel];
      arb_sum  = {1'b0, arb_x0} + {1'b0, arb_w};
      arb_skip = (arb_w == 10'd0) || ({1'b0, arb_x0} >= H_W);
      arb_end  = (arb_sum > H_W) ? H_W : arb_sum;
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      end_d       = end_q;
      sel_d       = sel_q;
      y_d         = y_q;
      pend_d      = pend_q;
      x0_d        = x0_q;
      w_d         = w_q;
      bsel_d      = bsel_q;
      drn_d       = drn_q;
      span_ack    = 3'b000;
      issue_layer = 3'b000;
      issue_X     = 10'd0;
      case (state_q)
         S_L1: begin
            issue_layer = 3'b001;
            issue_X     = x_q;
            if (x_q == X_LAST) begin
               state_d = S_ARB;
               x_d     = 10'd0;
            end else begin
               x_d = x_q + 10'd1;
            end
         end
         S_ARB: begin
            if (pend_q == 3'b000) begin
               state_d = S_DRAIN;
               drn_d   = DRN_LAST;
            end else if (arb_skip) begin
               span_ack[arb_sel] = 1'b1;
               pend_d[arb_sel]   = 1'b0;
            end else begin
               state_d = S_SPAN;
               sel_d   = arb_sel;
               x_d     = arb_x0;
               end_d   = arb_end;
            end
         end
         S_SPAN: begin
            issue_layer = 3'd2 + {1'b0, sel_q};
            issue_X     = x_q;
            if ({1'b0, x_q} + 11'd1 == end_q) begin
               span_ack[sel_q] = 1'b1;
               pend_d[sel_q]   = 1'b0;
               state_d         = S_ARB;
               x_d             = 10'd0;
            end else begin
               x_d = x_q + 10'd1;
            end
         end
         S_DRAIN: begin
            if (drn_q == 2'd0) state_d = S_IDLE;
            else               drn_d   = drn_q - 2'd1;
         end
         default: ;
      endcase
      // A new row pre-empts everything; dropped spans never ack.
      if (accept) begin
         state_d  = S_L1;
         x_d      = 10'd0;
         y_d      = row_y;
         pend_d   = span_req;
         x0_d     = span_x0;
         w_d      = span_w;
         bsel_d   = row_y[0];
         span_ack = 3'b000;
      end
   end

   always_ff @(posedge Clk50 or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         end_q   <= '0;
         sel_q   <= '0;
         y_q     <= '0;
         pend_q  <= '0;
         x0_q    <= '0;
         w_q     <= '0;
         bsel_q  <= 1'b0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         end_q   <= end_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         pend_q  <= pend_d;
         x0_q    <= x0_d;
         w_q     <= w_d;
         bsel_q  <= bsel_d;
         drn_q   <= drn_d;
      end
   end

   always_ff @(posedge Clk50 or posedge Reset) begin
      if (Reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= '{x: issue_X, y: issue_Y, layer: issue_layer};
         for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign write_X           = pipe_q[ROM_LAT-1].x;
   assign write_Y           = pipe_q[ROM_LAT-1].y;
   assign write_which_layer = pipe_q[ROM_LAT-1].layer;

`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q;
   always_ff @(posedge Clk50 or posedge Reset) begin
      if (Reset)                             ovr_cnt_q <= 8'd0;
      else if (overrun && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
   end
   assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_layer_write_scheduler.sv
// Scoreboard bench for layer_write_scheduler: a per-row timeline model pushes expected
// issue/write/ack/overrun events with cycle stamps; a negedge monitor pops and compares.
module tb_layer_write_scheduler;
   localparam int H = 640, V = 480, RL = 1;

   logic Clk50 = 1'b0, Reset, row_start;
   logic [9:0] row_y;
   logic [2:0] span_req;
   logic [29:0] span_x0, span_w;
   logic [9:0] issue_X, issue_Y, write_X, write_Y;
   logic [2:0] issue_layer, write_which_layer, span_ack;
   logic buffer_select, busy, overrun;
`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0] overrun_count;
`endif

   layer_write_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .ROM_LAT(RL)) dut (
      .Clk50(Clk50), .Reset(Reset), .row_start(row_start), .row_y(row_y),
      .span_req(span_req), .span_x0(span_x0), .span_w(span_w),
      .issue_X(issue_X), .issue_Y(issue_Y), .issue_layer(issue_layer),
      .write_X(write_X), .write_Y(write_Y), .write_which_layer(write_which_layer),
      .buffer_select(buffer_select), .busy(busy), .span_ack(span_ack), .overrun(overrun)
`ifdef SCHED_OVERRUN_CNT_EN
      ,.overrun_count(overrun_count)
`endif
   );

   always #5 Clk50 = ~Clk50;

   int cyc = 0;
   always @(posedge Clk50) cyc <= cyc + 1;

   typedef struct {int cyc; logic [9:0] x; logic [9:0] y; logic [2:0] layer; logic bsel;} pix_t;
   typedef struct {int cyc; logic [2:0] ack;} ack_t;
   pix_t iss_q[$], wr_q[$];
   ack_t ack_q[$];
   int   ovr_q[$];
   int   total = 0, bad = 0, busy_exp = 0, busy_obs = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge Clk50); #1;
   endtask

   task automatic put_pix(input int c0, input int t, input int x, input int y, input int lay,
                          input int cut, input bit push);
      pix_t p;
      if (push && (cut < 0 || t <= cut)) begin
         p.cyc = c0 + 1 + t; p.x = 10'(x); p.y = 10'(y); p.layer = 3'(lay); p.bsel = y[0];
         iss_q.push_back(p);
         p.cyc += RL;
         wr_q.push_back(p);
      end
   endtask

   task automatic put_ack(input int c0, input int t, input int k, input int cut, input bit push);
      if (push && (cut < 0 || t < cut)) ack_q.push_back('{c0 + 1 + t, 3'(1 << k)});
   endtask

   // Timeline of one pass: index 0 is the cycle after row_start is sampled.
   task automatic plan(input int c0, input int y, input int req, input int x0[3], input int w[3],
                       input int cut, input bit push, output int len);
      int t, e;
      t = 0;
      for (int x = 0; x < H; x++) begin put_pix(c0, t, x, y, 1, cut, push); t++; end
      for (int k = 0; k < 3; k++) begin
         if (req[k]) begin
            if (w[k] == 0 || x0[k] >= H) begin
               put_ack(c0, t, k, cut, push); t++;
            end else begin
               t++;
               e = (x0[k] + w[k] > H) ? H : x0[k] + w[k];
               for (int x = x0[k]; x < e; x++) begin
                  put_pix(c0, t, x, y, k + 2, cut, push);
                  if (x == e - 1) put_ack(c0, t, k, cut, push);
                  t++;
               end
            end
         end
      end
      t += 1 + RL;
      len = t;
   endtask

   task automatic do_row(input int y, input int req, input int x0[3], input int w[3],
                         input int cut, input int inj, input int gap);
      int len, c0;
      c0 = cyc;
      plan(c0, y, req, x0, w, cut, 1'b1, len);
      row_start = 1'b1; row_y = 10'(y); span_req = 3'(req);
      span_x0 = {10'(x0[2]), 10'(x0[1]), 10'(x0[0])};
      span_w  = {10'(w[2]), 10'(w[1]), 10'(w[0])};
      tick;
      row_start = 1'b0; row_y = 10'($urandom); span_req = 3'($urandom);
      span_x0 = 30'($urandom); span_w = 30'($urandom);
      if (cut >= 0) begin
         busy_exp += cut + 1;
         ovr_q.push_back(c0 + 1 + cut);
         repeat (cut) tick;
      end else begin
         busy_exp += len;
         if (inj > 0) begin
            repeat (inj) tick;
            row_start = 1'b1; row_y = 10'(V + $urandom_range(0, 1023 - V));
            tick;
            row_start = 1'b0;
            repeat (len + gap - inj - 1) tick;
         end else begin
            repeat (len + gap) tick;
         end
      end
   endtask

   pix_t m_p;
   ack_t m_a;
   int   m_o;
   always @(negedge Clk50) begin
      if (mon_en) begin
         if (busy) busy_obs++;
         if (issue_layer != 3'b000) begin
            if (iss_q.size() == 0) chk("issue_unexpected", issue_layer, 0);
            else begin
               m_p = iss_q.pop_front();
               chk("issue_cycle", cyc, m_p.cyc);
               chk("issue_X", issue_X, m_p.x);
               chk("issue_Y", issue_Y, m_p.y);
               chk("issue_layer", issue_layer, m_p.layer);
               chk("buffer_select", buffer_select, m_p.bsel);
            end
         end else begin
            chk("idle_issue_X", issue_X, 0);
         end
         if (write_which_layer != 3'b000) begin
            if (wr_q.size() == 0) chk("write_unexpected", write_which_layer, 0);
            else begin
               m_p = wr_q.pop_front();
               chk("write_cycle", cyc, m_p.cyc);
               chk("write_X", write_X, m_p.x);
               chk("write_Y", write_Y, m_p.y);
               chk("write_layer", write_which_layer, m_p.layer);
            end
         end
         if (span_ack != 3'b000) begin
            if (ack_q.size() == 0) chk("ack_unexpected", span_ack, 0);
            else begin
               m_a = ack_q.pop_front();
               chk("ack_cycle", cyc, m_a.cyc);
               chk("ack_bits", span_ack, m_a.ack);
            end
         end
         if (overrun) begin
            if (ovr_q.size() == 0) chk("overrun_unexpected", 1, 0);
            else begin
               m_o = ovr_q.pop_front();
               chk("overrun_cycle", cyc, m_o);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_issue_X"}, issue_X, 0);
      chk({tag, "_issue_Y"}, issue_Y, 0);
      chk({tag, "_issue_layer"}, issue_layer, 0);
      chk({tag, "_write_X"}, write_X, 0);
      chk({tag, "_write_Y"}, write_Y, 0);
      chk({tag, "_write_layer"}, write_which_layer, 0);
      chk({tag, "_buffer_select"}, buffer_select, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_span_ack"}, span_ack, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      int z[3], a[3], b[3], len, c0;
      z = '{0, 0, 0};
      Reset = 1'b1; row_start = 1'b0; row_y = '0; span_req = '0; span_x0 = '0; span_w = '0;
      repeat (3) tick;
      chk_all_zero("reset");
      Reset = 1'b0;
      tick;
      mon_en = 1'b1;

      do_row(10, 3'b000, z, z, -1, 0, 3);
      a = '{100, 0, 600}; b = '{44, 0, 100};
      do_row(5, 3'b101, a, b, -1, 0, 2);
      a = '{0, 50, 0}; b = '{0, 0, 0};
      do_row(7, 3'b010, a, b, -1, 0, 2);
      a = '{0, 600, 639}; b = '{0, 1023, 1};
      do_row(12, 3'b110, a, b, -1, 0, 2);
      do_row(9, 3'b000, z, z, 300, 0, 0);
      do_row(11, 3'b000, z, z, -1, 0, 2);
`ifdef SCHED_OVERRUN_CNT_EN
      chk("overrun_count_one", overrun_count, 1);
`endif

      row_start = 1'b1; row_y = 10'd480;
      #1 chk("invalid_row_overrun", overrun, 0);
      tick;
      row_start = 1'b0;
      chk("invalid_row_busy0", busy, 0);
      tick;
      chk("invalid_row_busy1", busy, 0);

      for (int r = 0; r < 14; r++) begin
         int y, req, x0[3], w[3], cut, inj;
         y = $urandom_range(0, V - 1);
         req = $urandom_range(0, 7);
         for (int k = 0; k < 3; k++) begin
            x0[k] = $urandom_range(0, 700);
            if ($urandom_range(0, 4) == 0)      w[k] = 0;
            else if ($urandom_range(0, 5) == 0) w[k] = $urandom_range(0, 1023);
            else                                w[k] = $urandom_range(1, 200);
         end
         plan(0, y, req, x0, w, -1, 1'b0, len);
         cut = (r < 13 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         inj = (cut < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : 0;
         do_row(y, req, x0, w, cut, inj, $urandom_range(1, 4));
      end

      for (int i = 0; i < 300; i++) do_row(i % V, 3'b000, z, z, 0, 0, 0);
      do_row(3, 3'b000, z, z, -1, 0, 2);
`ifdef SCHED_OVERRUN_CNT_EN
      chk("overrun_count_sat", overrun_count, 255);
`endif

      a = '{100, 0, 0}; b = '{44, 0, 0};
      c0 = cyc;
      plan(c0, 5, 3'b001, a, b, -1, 1'b1, len);
      row_start = 1'b1; row_y = 10'd5; span_req = 3'b001;
      span_x0 = {10'd0, 10'd0, 10'd100}; span_w = {10'd0, 10'd0, 10'd44};
      tick;
      row_start = 1'b0;
      repeat (661) tick;
      chk("pre_reset_issue_X", issue_X, 120);
      chk("pre_reset_issue_layer", issue_layer, 2);
      busy_exp += 661;
      mon_en = 1'b0;
      Reset = 1'b1;
      #1 chk_all_zero("midpass_reset");
      repeat (2) tick;
      chk_all_zero("held_reset");
`ifdef SCHED_OVERRUN_CNT_EN
      chk("overrun_count_reset", overrun_count, 0);
`endif
      Reset = 1'b0;
      tick;
      chk("post_reset_busy", busy, 0);
      chk("post_reset_issue_layer", issue_layer, 0);
      iss_q.delete(); wr_q.delete(); ack_q.delete(); ovr_q.delete();
      mon_en = 1'b1;

      a = '{$urandom_range(0, 300), $urandom_range(300, 639), $urandom_range(0, 639)};
      b = '{$urandom_range(1, 100), $urandom_range(1, 400), $urandom_range(1, 50)};
      do_row(20, 3'b111, a, b, -1, 0, 3);

      repeat (2) tick;
      mon_en = 1'b0;
      chk("issue_queue_empty", iss_q.size(), 0);
      chk("write_queue_empty", wr_q.size(), 0);
      chk("ack_queue_empty", ack_q.size(), 0);
      chk("overrun_queue_empty", ovr_q.size(), 0);
      chk("busy_cycles", busy_obs, busy_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/layer_write_scheduler.md
LAYER_WRITE_SCHEDULER -- requirements
Module: layer_write_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per row.
REQ-002 Parameter V_ACTIVE, default 480, visible rows.
REQ-003 Parameter ROM_LAT, default 1, sprite ROM read latency in Clk50 cycles (1..3).
REQ-004 Clk50  in  1  sole clock; all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 row_start  in  1  single-cycle pulse; begin rendering row row_y into the back buffer.
REQ-007 row_y  in  10  row to render; sampled only on row_start.
REQ-008 span_req  in  3  bit k is a pending sprite span for layer k+2 (layers 2..4); sampled only on row_start.
REQ-009 span_x0  in  30  packed 10-bit start X per span; bits [9:0] are layer 2.
REQ-010 span_w  in  30  packed 10-bit span widths; same packing as span_x0.
REQ-011 issue_X, issue_Y  out  10 each  address-generator coordinates for the current issue cycle.
REQ-012 issue_layer  out  3  001..100 = layer 1..4 being issued; 000 = none.
REQ-013 write_X, write_Y  out  10 each  issue_X/issue_Y delayed ROM_LAT cycles.
REQ-014 write_which_layer  out  3  issue_layer delayed ROM_LAT cycles; aligned with ROM data.
REQ-015 buffer_select  out  1  row_y[0] of the row in progress.
REQ-016 busy  out  1  high from the cycle after an accepted row_start until drain completes.
REQ-017 span_ack  out  3  one-cycle pulse when the corresponding span finishes issuing or is skipped.
REQ-018 overrun  out  1  one-cycle pulse when row_start arrives while busy.

Function
REQ-019 States are IDLE, L1, ARB, SPAN and DRAIN; the FSM enters L1 on an accepted row_start.
REQ-020 A row_start SHALL be accepted only if row_y < V_ACTIVE; otherwise it is ignored, with no state change and no overrun.
REQ-021 On acceptance, the block latches row_y, the span_req mask, span_x0 and span_w.
REQ-022 In L1, issue_X steps 0..H_ACTIVE-1 at one pixel per cycle with issue_layer=001; after the last pixel the FSM goes to ARB.
REQ-023 In ARB (1 cycle), the FSM selects the lowest pending layer (2 before 3 before 4) and goes to SPAN; with none pending it goes to DRAIN.
REQ-024 In SPAN, issue_X steps x0..min(x0+w,H_ACTIVE)-1; at the last pixel the span's ack pulses, its pending bit clears, and the FSM returns to ARB.
REQ-025 A span with w=0 or x0>=H_ACTIVE is skipped: its ack pulses in the ARB cycle, no pixels issue, and ARB re-evaluates on the next cycle.
REQ-026 The x0+w arithmetic is 11 bits wide, so there is no wrap-around, and the result is clipped to H_ACTIVE.
REQ-027 DRAIN lasts ROM_LAT cycles with issue_layer=000, then the FSM goes to IDLE and busy falls.
REQ-028 issue_Y equals the latched row_y throughout a pass; issue_layer=000 and issue_X=0 whenever not issuing.
REQ-029 The write_* pipeline is a ROM_LAT-deep shift register that always shifts, including during abort and DRAIN.
REQ-030 row_start while busy, with row_y valid: overrun pulses, all pending spans are dropped without ack, and the new row is latched and restarts at L1 on the next cycle; in-flight pipeline entries still drain out.
REQ-031 buffer_select updates on acceptance and holds through DRAIN.

Reset
REQ-032 Reset forces the FSM to IDLE, takes effect immediately and mid-pass, and clears latched spans without ack.
REQ-033 During reset, all outputs are 0: issue_*, write_*, buffer_select, busy, span_ack and overrun; the pipeline is cleared.

Configuration
REQ-034 With SCHED_OVERRUN_CNT_EN defined, an added output overrun_count (8 bits) counts overrun pulses, saturates at 255, and is cleared only by Reset.
REQ-035 Without SCHED_OVERRUN_CNT_EN, the port and the counter are absent and all other behaviour is identical.

Verification
REQ-036 Case: ROM_LAT=1, row_start with row_y=10 and span_req=000 -> 640 issue cycles of layer 001 with X 0..639, write_* lagging by 1 cycle, busy high for 640+1+1 cycles, buffer_select=0.
REQ-037 Case: row_y=5, span_req=101, layer2 span x0=100,w=44, layer4 span x0=600,w=100 -> after L1, layer 010 issues X 100..143 and then layer 100 issues X 600..639 (clipped); ack[0] pulses then ack[2]; buffer_select=1.
REQ-038 Case: span_req=010 with layer3 w=0 -> ack[1] pulses in ARB, no layer-011 pixels issue, then DRAIN.
REQ-039 Case: second row_start (row_y=11) at L1 X=300 -> overrun pulses, no acks, restart at X=0 with issue_Y=11; with the macro defined, overrun_count=1.
REQ-040 Case: row_y=480 -> ignored, busy stays 0; Reset asserted at SPAN X=120 -> all outputs 0 immediately and FSM in IDLE after release.
REQ-041 Case: macro defined, 300 overruns -> overrun_count=255.
